// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and the overflow helper shared by alu_seq and its engine
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
  function automatic logic add_of(input logic sa, input logic sb, input logic sr, input logic sub);
    return sub ? (sa != sb) && (sr != sa) : (sa == sb) && (sr != sa);
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// Ports: clk, rst_n (async active-low); start loads a, b and div (1=divide);
//        done is high during the final step, with lo (product low / quotient)
//        and hi (product high / remainder) valid alongside it.
module alu_muldiv_iter #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic [WIDTH-1:0] acc, q, d;
  logic [CNT_W-1:0] cnt;
  logic div_op;
  logic [WIDTH:0] sum, rem, diff;
  // {acc,q} is the double-width working register: shifted right for MUL, left for DIV
  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
    rem = {acc, q[WIDTH-1]};
    diff = rem - {1'b0, d};
    hi = div_op ? (diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo = div_op ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
  end
  assign done = cnt == CNT_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      div_op <= 1'b0;
    end else if (start) begin
      acc <= '0;
      q <= a;
      d <= b;
      cnt <= CNT_W'(WIDTH);
      div_op <= div;
    end else if (cnt != '0) begin
      acc <= hi;
      q <= lo;
      cnt <= cnt - CNT_W'(1);
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and optional iterative MUL/DIV
// Ports: clk, rst_n (async active-low); in_valid/in_ready, op, a, b inputs;
//        out_valid one-cycle pulse with out, r15 (MUL high / DIV remainder), of.
// Macro ALU_MULDIV_EN: enables multi-cycle MUL/DIV; without it ops 110/111 set of.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] r15,
  output logic             of
);
  state_t state;
  logic go, long_op, s_of;
  logic [WIDTH-1:0] s_out, s_r15, sum, dif;
  logic [2*WIDTH-1:0] wide;
  assign in_ready = state == ST_IDLE;
  assign go = in_valid && in_ready;
  always_comb begin
    sum = a + b;
    dif = a - b;
    wide = {{WIDTH{1'b0}}, a} << b[CNT_W-2:0];
    s_out = '0;
    s_r15 = '0;
    s_of = 1'b0;
    case (op)
      OP_ADD: begin
        s_out = sum;
        s_of = add_of(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        s_out = dif;
        s_of = add_of(a[WIDTH-1], b[WIDTH-1], dif[WIDTH-1], 1'b1);
      end
      OP_AND: s_out = a & b;
      OP_OR:  s_out = a | b;
      OP_XOR: s_out = a ^ b;
      OP_SHL: begin
        s_out = wide[WIDTH-1:0];
        s_of = |wide[2*WIDTH-1:WIDTH];
      end
      default: begin
`ifdef ALU_MULDIV_EN
        // only DIV by zero reaches here; MUL always takes the iterative path
        s_out = '1;
        s_r15 = a;
`endif
        s_of = 1'b1;
      end
    endcase
  end
`ifdef ALU_MULDIV_EN
  logic done;
  logic [WIDTH-1:0] m_lo, m_hi;
  assign long_op = op == OP_MUL || (op == OP_DIV && b != '0);
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk),
    .rst_n(rst_n),
    .start(go && long_op),
    .div(op == OP_DIV),
    .a(a),
    .b(b),
    .done(done),
    .lo(m_lo),
    .hi(m_hi)
  );
`else
  assign long_op = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      out <= '0;
      r15 <= '0;
      of <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (go && !long_op) begin
        out <= s_out;
        r15 <= s_r15;
        of <= s_of;
        out_valid <= 1'b1;
      end
`ifdef ALU_MULDIV_EN
      if (go && long_op) state <= op == OP_MUL ? ST_MUL : ST_DIV;
      if (done && state != ST_IDLE) begin
        state <= ST_IDLE;
        out <= m_lo;
        r15 <= m_hi;
        of <= state == ST_MUL && m_hi != '0;
        out_valid <= 1'b1;
      end
`endif
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a scoreboard queue checked by an independent output monitor
module tb_alu_seq;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  typedef struct {
    string nm;
    logic [15:0] o;
    logic [15:0] r;
    logic f;
    int due;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, out_valid, of;
  logic [2:0] op = 3'b000;
  logic [15:0] a = '0, b = '0, out, r15;
  int checks = 0, errors = 0, cyc = 0, ready_lows = 0;
  exp_t sbq[$];
  exp_t e;
  alu_seq #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out(out),
    .r15(r15),
    .of(of)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && !in_ready) ready_lows++;
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid act=%h exp=none", out);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_out"}, {16'h0, out}, {16'h0, e.o});
        chk({e.nm, "_r15"}, {16'h0, r15}, {16'h0, e.r});
        chk({e.nm, "_of"}, {31'h0, of}, {31'h0, e.f});
        chk({e.nm, "_cycle"}, cyc, e.due);
      end
    end
  end
  task automatic send(input string nm, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] eo, input logic [15:0] er, input logic ef, input int lat, input bit push);
    exp_t t;
    int n = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({nm, "_ready_timeout"}, 0, 1);
    t.nm = nm;
    t.o = eo;
    t.r = er;
    t.f = ef;
    t.due = cyc + lat;
    if (push) sbq.push_back(t);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic muldiv(input string nm, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] eo, input logic [15:0] er, input logic ef);
    if (MD) send(nm, o, x, y, eo, er, ef, 17, 1'b1);
    else send(nm, o, x, y, 16'h0, 16'h0, 1'b1, 1, 1'b1);
  endtask
  initial begin
    int busy, n;
    repeat (3) @(negedge clk);
    chk("rst_out", {16'h0, out}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_r15", {16'h0, r15}, 0);
    chk("idle_of", {31'h0, of}, 0);
    chk("idle_out_valid", {31'h0, out_valid}, 0);
    send("add", 3'b000, 16'h0F00, 16'h0050, 16'h0F50, 16'h0, 1'b0, 1, 1'b1);
    send("sub", 3'b001, 16'h0F50, 16'h0050, 16'h0F00, 16'h0, 1'b0, 1, 1'b1);
    send("add_of", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 1'b1, 1, 1'b1);
    send("sub_of", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 16'h0, 1'b1, 1, 1'b1);
    send("and", 3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0, 1'b0, 1, 1'b1);
    send("or", 3'b011, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0, 1'b0, 1, 1'b1);
    send("xor", 3'b100, 16'hAAAA, 16'hFFFF, 16'h5555, 16'h0, 1'b0, 1, 1'b1);
    send("shl", 3'b101, 16'h0001, 16'h0004, 16'h0010, 16'h0, 1'b0, 1, 1'b1);
    send("shl_of", 3'b101, 16'h8001, 16'h0001, 16'h0002, 16'h0, 1'b1, 1, 1'b1);
    send("shl_slice", 3'b101, 16'h3001, 16'h0013, 16'h8008, 16'h0, 1'b1, 1, 1'b1);
    muldiv("mul", 3'b110, 16'hFFFF, 16'h004C, 16'hFFB4, 16'h004B, 1'b1);
    busy = MD ? 1 : 0;
    op = 3'b000;
    a = 16'h0001;
    b = 16'h0001;
    in_valid = 1'b1;
    while (!in_ready && busy < 40) begin
      @(negedge clk);
      if (!in_ready) busy++;
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", busy, MD ? 16 : 0);
    @(negedge clk);
    muldiv("div", 3'b111, 16'hFF0F, 16'h00FF, 16'h0100, 16'h000F, 1'b0);
    if (MD) send("div0", 3'b111, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1, 1'b1);
    else send("div0", 3'b111, 16'h1234, 16'h0000, 16'h0, 16'h0, 1'b1, 1, 1'b1);
    muldiv("mul_small", 3'b110, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0);
    send("add_after_mul", 3'b000, 16'h1111, 16'h2222, 16'h3333, 16'h0, 1'b0, 1, 1'b1);
    send("mul_abort", 3'b110, 16'h0003, 16'h0005, 16'h0, 16'h0, 1'b1, 1, !MD);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", {16'h0, out}, 0);
    chk("abort_r15", {16'h0, r15}, 0);
    chk("abort_of", {31'h0, of}, 0);
    chk("abort_in_ready", {31'h0, in_ready}, 1);
    chk("abort_out_valid", {31'h0, out_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send("add_post_rst", 3'b000, 16'h0001, 16'h0002, 16'h0003, 16'h0, 1'b0, 1, 1'b1);
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    if (!MD) chk("in_ready_never_low", ready_lows, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
